// File: rtl/mc_if.sv
// Control-unit bundle between the multi-cycle sequencer and the datapath/memory side.
// master = sequencer (drives enables), slave = datapath/memory environment.
interface mc_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ALU_W   = 4
);
  logic [INSTR_W-1:0] decoded_instr;
  logic [ALU_W-1:0]   alu_control_in;
  logic               zero_signal;
  logic               mem_ready;
  logic               md_done;
  logic               imem_req;
  logic               ir_w;
  logic               pc_w;
  logic [1:0]         pc_sel;
  logic [ALU_W-1:0]   alu_control;
  logic               d_r;
  logic               d_w;
  logic               md_start;
  logic               regfile_w;
  logic               instr_done;
  logic               illegal;
  logic               bus_err;
  logic [2:0]         state;

  modport master (
    input  decoded_instr, alu_control_in, zero_signal, mem_ready, md_done,
    output imem_req, ir_w, pc_w, pc_sel, alu_control, d_r, d_w, md_start,
    output regfile_w, instr_done, illegal, bus_err, state
  );

  modport slave (
    output decoded_instr, alu_control_in, zero_signal, mem_ready, md_done,
    input  imem_req, ir_w, pc_w, pc_sel, alu_control, d_r, d_w, md_start,
    input  regfile_w, instr_done, illegal, bus_err, state
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEMACC/WB with mult/div wait,
// memory watchdog and illegal-instruction trap.
module mc_controller #(
  parameter int unsigned        INSTR_W     = 32,
  parameter int unsigned        ALU_W       = 4,
  parameter logic [INSTR_W-1:0] MD_MASK     = 32'h8000_0000,
  parameter int unsigned        MEM_TIMEOUT = 16,
  parameter int unsigned        JR_BIT      = 16,
  parameter int unsigned        LW_BIT      = 23,
  parameter int unsigned        SW_BIT      = 24,
  parameter int unsigned        BEQ_BIT     = 25,
  parameter int unsigned        BNE_BIT     = 26,
  parameter int unsigned        J_BIT       = 29,
  parameter int unsigned        JAL_BIT     = 30
) (
  input logic clk,
  input logic rst_n,
  mc_if.master bus
);
  localparam int unsigned WdW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMemAcc = 3'd3,
    StWb     = 3'd4,
    StMdWait = 3'd5,
    StTrap   = 3'd6
  } state_e;

  typedef struct packed {
    logic lw, sw, beq, bne, j, jr, jal;
  } cls_t;

  state_e             state_q, state_d;
  cls_t               cls_q, cls_d;
  logic [ALU_W-1:0]   alu_q, alu_d;
  logic [WdW-1:0]     wd_q, wd_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic               md_start_q, md_start_d;

  logic               imem, irw, pcw, dr, dw, rfw, done;
  logic [1:0]         sel;
  logic [INSTR_W-1:0] instr;
  logic               onehot, is_md, wd_limit;

  assign instr    = bus.decoded_instr;
  assign onehot   = (instr != '0) && ((instr & (instr - INSTR_W'(1))) == '0);
  assign is_md    = (instr & MD_MASK) != '0;
  assign wd_limit = (wd_q == WdW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    alu_d      = alu_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    md_start_d = 1'b0;
    imem = 1'b0; irw = 1'b0; pcw = 1'b0; sel = 2'b00;
    dr   = 1'b0; dw  = 1'b0; rfw = 1'b0; done = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem = 1'b1;
        if (bus.mem_ready) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = StDecode;
        end else if (wd_limit) begin
          bus_err_d = 1'b1;
          state_d   = StTrap;
        end
      end
      StDecode: begin
        if (!onehot) begin
          illegal_d = 1'b1;
          state_d   = StTrap;
        end else begin
          alu_d = bus.alu_control_in;
          cls_d = '{lw: instr[LW_BIT], sw: instr[SW_BIT], beq: instr[BEQ_BIT],
                    bne: instr[BNE_BIT], j: instr[J_BIT], jr: instr[JR_BIT],
                    jal: instr[JAL_BIT]};
          if (is_md) begin
            md_start_d = 1'b1;
            state_d    = StMdWait;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (cls_q.beq || cls_q.bne) begin
          // Taken when zero matches beq, or mismatches bne.
          if (cls_q.beq == bus.zero_signal) begin
            pcw = 1'b1;
            sel = 2'b11;
          end
          done    = 1'b1;
          state_d = StFetch;
        end else if (cls_q.j || cls_q.jr) begin
          pcw     = 1'b1;
          sel     = cls_q.jr ? 2'b10 : 2'b01;
          done    = 1'b1;
          state_d = StFetch;
        end else if (cls_q.jal) begin
          pcw     = 1'b1;
          sel     = 2'b01;
          state_d = StWb;
        end else if (cls_q.lw || cls_q.sw) begin
          state_d = StMemAcc;
        end else begin
          state_d = StWb;
        end
      end
      StMemAcc: begin
        dr = cls_q.lw;
        dw = cls_q.sw;
        if (bus.mem_ready) begin
          done    = cls_q.sw;
          state_d = cls_q.lw ? StWb : StFetch;
        end else if (wd_limit) begin
          bus_err_d = 1'b1;
          state_d   = StTrap;
        end
      end
      StMdWait: if (bus.md_done) state_d = StWb;
      StWb: begin
        rfw     = 1'b1;
        done    = 1'b1;
        state_d = StFetch;
      end
      StTrap: ;
      default: state_d = StTrap;
    endcase

    if (state_d != state_q) begin
      wd_d = '0;
    end else if ((state_q == StFetch || state_q == StMemAcc) && !bus.mem_ready) begin
      wd_d = wd_q + WdW'(1);
    end else begin
      wd_d = wd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      cls_q      <= '0;
      alu_q      <= '0;
      wd_q       <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      md_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      alu_q      <= alu_d;
      wd_q       <= wd_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
      md_start_q <= md_start_d;
    end
  end

  // Gate with rst_n so nothing (notably write strobes) escapes in the cycle reset asserts.
  assign bus.imem_req    = rst_n & imem;
  assign bus.ir_w        = rst_n & irw;
  assign bus.pc_w        = rst_n & pcw;
  assign bus.pc_sel      = rst_n ? sel : 2'b00;
  assign bus.d_r         = rst_n & dr;
  assign bus.d_w         = rst_n & dw;
  assign bus.regfile_w   = rst_n & rfw;
  assign bus.instr_done  = rst_n & done;
  assign bus.md_start    = rst_n & md_start_q;
  assign bus.alu_control = rst_n ? alu_q : '0;
  assign bus.illegal     = rst_n & illegal_q;
  assign bus.bus_err     = rst_n & bus_err_q;
  assign bus.state       = rst_n ? state_q : StFetch;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle expected traces built from instruction rules.
module tb_mc_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_if #(.INSTR_W(32), .ALU_W(4)) bus ();

  mc_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vec  = 0;
  int errs = 0;

  // Stimulus (mr, md, z, dec) and expected outputs for one clock cycle.
  typedef struct packed {
    logic       mr, md, z, dec;
    logic [2:0] st;
    logic       imem, irw, pcw;
    logic [1:0] sel;
    logic       dr, dw, rfw, done, mds;
  } step_t;

  step_t       plan[$];
  logic [31:0] cur_instr;
  logic [3:0]  cur_alu;

  function automatic logic [14:0] obs();
    return {bus.state, bus.imem_req, bus.ir_w, bus.pc_w, bus.pc_sel, bus.d_r, bus.d_w,
            bus.regfile_w, bus.instr_done, bus.md_start, bus.illegal, bus.bus_err};
  endfunction

  function automatic logic [14:0] pk(step_t s, logic ill, logic be);
    return {s.st, s.imem, s.irw, s.pcw, s.sel, s.dr, s.dw, s.rfw, s.done, s.mds, ill, be};
  endfunction

  function automatic step_t mk(logic [2:0] st);
    step_t s;
    s    = '0;
    s.st = st;
    s.mr = 1'($urandom);
    s.md = 1'($urandom);
    s.z  = 1'($urandom);
    return s;
  endfunction

  task automatic chk(string tag, logic [14:0] o, logic [14:0] e);
    vec++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Expected trace for one instruction at one-hot bit b.
  // f: fetch stall cycles, m: memory stall cycles, n: MDWAIT cycles incl. md_done.
  task automatic build(int b, logic z, int f, int m, int n);
    step_t s;
    logic  wb;
    wb        = 1'b0;
    cur_instr = 32'd1 << b;
    cur_alu   = 4'($urandom);
    repeat (f) begin
      s = mk(3'd0); s.mr = 1'b0; s.imem = 1'b1; plan.push_back(s);
    end
    s = mk(3'd0); s.mr = 1'b1; s.imem = 1'b1; s.irw = 1'b1; s.pcw = 1'b1; plan.push_back(s);
    s = mk(3'd1); s.dec = 1'b1; plan.push_back(s);
    if (b == 31) begin
      for (int i = 1; i <= n; i++) begin
        s = mk(3'd5); s.md = (i == n); s.mds = (i == 1); plan.push_back(s);
      end
      wb = 1'b1;
    end else begin
      s = mk(3'd2); s.z = z;
      case (b)
        25, 26: begin
          s.done = 1'b1;
          if ((b == 25) == z) begin s.pcw = 1'b1; s.sel = 2'd3; end
          plan.push_back(s);
        end
        29: begin s.pcw = 1'b1; s.sel = 2'd1; s.done = 1'b1; plan.push_back(s); end
        16: begin s.pcw = 1'b1; s.sel = 2'd2; s.done = 1'b1; plan.push_back(s); end
        30: begin s.pcw = 1'b1; s.sel = 2'd1; plan.push_back(s); wb = 1'b1; end
        23, 24: begin
          plan.push_back(s);
          repeat (m) begin
            s = mk(3'd3); s.mr = 1'b0; s.dr = (b == 23); s.dw = (b == 24); plan.push_back(s);
          end
          s = mk(3'd3); s.mr = 1'b1; s.dr = (b == 23); s.dw = (b == 24); s.done = (b == 24);
          plan.push_back(s);
          wb = (b == 23);
        end
        default: begin plan.push_back(s); wb = 1'b1; end
      endcase
    end
    if (wb) begin
      s = mk(3'd4); s.rfw = 1'b1; s.done = 1'b1; plan.push_back(s);
    end
  endtask

  task automatic run_plan(string tag, logic tail);
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clk);
      bus.mem_ready      = s.mr;
      bus.md_done        = s.md;
      bus.zero_signal    = s.z;
      bus.decoded_instr  = s.dec ? cur_instr : $urandom;
      bus.alu_control_in = s.dec ? cur_alu : 4'($urandom);
      #1 chk(tag, obs(), pk(s, 1'b0, 1'b0));
    end
    if (tail) begin
      @(posedge clk);
      #1 chk({tag, "_alu"}, 15'(bus.alu_control), 15'(cur_alu));
      chk({tag, "_ret"}, 15'(bus.state), 15'd0);
    end
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.mem_ready      = 1'b0;
    bus.md_done        = 1'b0;
    bus.zero_signal    = 1'b0;
    bus.decoded_instr  = '0;
    bus.alu_control_in = '0;
    #1 chk("rst_outs", obs(), 15'd0);
    chk("rst_alu", 15'(bus.alu_control), 15'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    step_t s;
    do_reset();

    build(0, 1'b0, 0, 0, 1);   run_plan("add", 1'b1);
    build(23, 1'b0, 0, 3, 1);  run_plan("lw_stall3", 1'b1);
    build(24, 1'b0, 1, 2, 1);  run_plan("sw", 1'b1);
    build(25, 1'b1, 0, 0, 1);  run_plan("beq_taken", 1'b1);
    build(25, 1'b0, 0, 0, 1);  run_plan("beq_not", 1'b1);
    build(26, 1'b0, 0, 0, 1);  run_plan("bne_taken", 1'b1);
    build(26, 1'b1, 0, 0, 1);  run_plan("bne_not", 1'b1);
    build(30, 1'b0, 0, 0, 1);  run_plan("jal", 1'b1);
    build(29, 1'b0, 2, 0, 1);  run_plan("j", 1'b1);
    build(16, 1'b0, 0, 0, 1);  run_plan("jr", 1'b1);
    build(31, 1'b0, 0, 0, 33); run_plan("md33", 1'b1);

    for (int i = 0; i < 60; i++) begin
      build($urandom_range(0, 31), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(1, 4));
      run_plan("rand", 1'b1);
    end

    // Illegal decodes: zero and two-hot.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      build(0, 1'b0, 0, 0, 1);
      void'(plan.pop_back());
      void'(plan.pop_back());
      cur_instr = (k == 0) ? 32'h0 : 32'h3;
      run_plan("illegal_dec", 1'b0);
      repeat (3) begin
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.md_done   = 1'b1;
        #1 chk("illegal_trap", obs(), pk(mk(3'd6), 1'b1, 1'b0));
      end
      do_reset();
      build(0, 1'b0, 0, 0, 1); run_plan("after_illegal", 1'b1);
    end

    // Watchdog: 16 not-ready fetch cycles trap.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      s = mk(3'd0); s.imem = 1'b1;
      #1 chk("wd_stall", obs(), pk(s, 1'b0, 1'b0));
    end
    repeat (2) begin
      @(negedge clk);
      bus.mem_ready = 1'b1;
      #1 chk("wd_trap", obs(), pk(mk(3'd6), 1'b0, 1'b1));
    end

    // Ready on the limiting cycle wins.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      s = mk(3'd0); s.imem = 1'b1;
      #1 chk("wd_edge_stall", obs(), pk(s, 1'b0, 1'b0));
    end
    @(negedge clk);
    bus.mem_ready = 1'b1;
    s = mk(3'd0); s.imem = 1'b1; s.irw = 1'b1; s.pcw = 1'b1;
    #1 chk("wd_edge_ready", obs(), pk(s, 1'b0, 1'b0));
    @(negedge clk);
    #1 chk("wd_edge_notrap", obs(), pk(mk(3'd1), 1'b0, 1'b0));

    // Reset mid-MEMACC of a store.
    do_reset();
    build(24, 1'b0, 0, 2, 1);
    void'(plan.pop_back());
    run_plan("sw_pre_abort", 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("abort_dw", 15'(bus.d_w), 15'd0);
    chk("abort_outs", obs(), 15'd0);
    do_reset();
    build(0, 1'b0, 0, 0, 1); run_plan("after_abort", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
